// File: rtl/pll_rst_pkg.sv
// Shared types and constants for the PLL lock-qualified reset generator.
package pll_rst_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_FILTER    = 3'd1,
    ST_HOLD      = 3'd2,
    ST_RUN       = 3'd3,
    ST_LOST      = 3'd4
  } state_e;

  localparam int unsigned LOSS_CNT_W = 8;
  localparam logic [LOSS_CNT_W-1:0] LOSS_CNT_MAX = '1;

  // Counter width covering both the filter and hold intervals, never below 1 bit.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return ($clog2(m) < 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/pll_lock_reset_ctrl_bit_sync.sv
// Single-bit multi-flop synchronizer with synchronous clear.
module bit_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_reset_ctrl.sv
// Lock-qualified fabric reset generator: filters the PLL lock flag, holds reset
// for a programmable interval after lock, and tracks lock-loss events.
module pll_lock_reset_ctrl
  import pll_rst_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned LOCK_FILTER = 16,
  parameter int unsigned RST_HOLD    = 1024
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  PLL_LOCK_I,
  input  logic                  RST_REQ,
  output logic                  FABRIC_RST,
  output logic                  FABRIC_RST_N,
  output logic                  READY,
  output logic                  LOCK_LOST,
  output logic [LOSS_CNT_W-1:0] LOSS_CNT,
  output logic [2:0]            STATE
);

  localparam int unsigned CNT_W = cnt_width(LOCK_FILTER, RST_HOLD);
  localparam logic [CNT_W-1:0] FILTER_LAST = CNT_W'(LOCK_FILTER - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RST_HOLD - 1);

  logic lock_s;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  fabric_rst_q, fabric_rst_d;
  logic                  fabric_rst_n_q, fabric_rst_n_d;
  logic                  ready_q, ready_d;
  logic                  lock_lost_q, lock_lost_d;
  logic [LOSS_CNT_W-1:0] loss_cnt_q, loss_cnt_d;
  logic                  lost_entry;

  bit_sync #(
    .STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk(CLK),
    .rst(RST),
    .d  (PLL_LOCK_I),
    .q  (lock_s)
  );

  // Next-state, counter and status logic; outputs decode from the next state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lock_lost_d = lock_lost_q;
    loss_cnt_d  = loss_cnt_q;
    lost_entry  = 1'b0;

    case (state_q)
      ST_WAIT_LOCK: begin
        cnt_d = '0;
        if (lock_s) state_d = ST_FILTER;
      end
      ST_FILTER: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == FILTER_LAST) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (!lock_s) begin
          lost_entry = 1'b1;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          lost_entry = 1'b1;
        end else if (RST_REQ) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end
      end
      ST_LOST: begin
        state_d = ST_WAIT_LOCK;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase

    // Lock loss wins over a coincident soft reset request.
    if (lost_entry) begin
      state_d     = ST_LOST;
      cnt_d       = '0;
      lock_lost_d = 1'b1;
      if (loss_cnt_q != LOSS_CNT_MAX) loss_cnt_d = loss_cnt_q + LOSS_CNT_W'(1);
    end

    fabric_rst_d   = (state_d != ST_RUN);
    fabric_rst_n_d = (state_d == ST_RUN);
    ready_d        = (state_d == ST_RUN);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q        <= ST_WAIT_LOCK;
      cnt_q          <= '0;
      fabric_rst_q   <= 1'b1;
      fabric_rst_n_q <= 1'b0;
      ready_q        <= 1'b0;
      lock_lost_q    <= 1'b0;
      loss_cnt_q     <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      fabric_rst_q   <= fabric_rst_d;
      fabric_rst_n_q <= fabric_rst_n_d;
      ready_q        <= ready_d;
      lock_lost_q    <= lock_lost_d;
      loss_cnt_q     <= loss_cnt_d;
    end
  end

  assign FABRIC_RST   = fabric_rst_q;
  assign FABRIC_RST_N = fabric_rst_n_q;
  assign READY        = ready_q;
  assign LOCK_LOST    = lock_lost_q;
  assign LOSS_CNT     = loss_cnt_q;
  assign STATE        = state_q;

endmodule

// File: tb/tb_pll_lock_reset_ctrl.sv
// Self-checking bench for pll_lock_reset_ctrl: vector table, directed corner
// sequences, then randomized lock/request traffic against a timestamp model.
module tb_pll_lock_reset_ctrl;

  localparam int unsigned SS = 2;
  localparam int unsigned LF = 4;
  localparam int unsigned RH = 8;
  localparam int          UP_EDGES = SS + LF + RH + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lock_i = 1'b0;
  logic       rst_req = 1'b0;
  logic       fabric_rst, fabric_rst_n, ready, lock_lost;
  logic [7:0] loss_cnt;
  logic [2:0] state;

  int tests = 0;
  int fails = 0;

  pll_lock_reset_ctrl #(
    .SYNC_STAGES(SS),
    .LOCK_FILTER(LF),
    .RST_HOLD   (RH)
  ) dut (
    .CLK         (clk),
    .RST         (rst),
    .PLL_LOCK_I  (lock_i),
    .RST_REQ     (rst_req),
    .FABRIC_RST  (fabric_rst),
    .FABRIC_RST_N(fabric_rst_n),
    .READY       (ready),
    .LOCK_LOST   (lock_lost),
    .LOSS_CNT    (loss_cnt),
    .STATE       (state)
  );

  always #5 clk = ~clk;

  // Reference model: phases timed by edge timestamps rather than a counter.
  int   m_pipe [SS];
  int   m_mode  = 0;
  int   m_since = 0;
  int   m_cyc   = 0;
  int   m_lost  = 0;
  int   m_cnt   = 0;
  logic cur_rst = 1'b1, cur_lock = 1'b0, cur_req = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    int ls;
    ls = m_pipe[SS-1];
    m_cyc++;
    if (cur_rst) begin
      m_mode = 0;
      m_lost = 0;
      m_cnt  = 0;
      for (int i = 0; i < int'(SS); i++) m_pipe[i] = 0;
      return;
    end
    case (m_mode)
      0: if (ls != 0) begin m_mode = 1; m_since = m_cyc; end
      1: begin
        if (ls == 0) m_mode = 0;
        else if (m_cyc - m_since == int'(LF)) begin m_mode = 2; m_since = m_cyc; end
      end
      2, 3: begin
        if (ls == 0) begin
          m_mode = 4;
          m_lost = 1;
          m_cnt  = (m_cnt < 255) ? m_cnt + 1 : 255;
        end else if (m_mode == 2 && m_cyc - m_since == int'(RH)) begin
          m_mode = 3;
        end else if (m_mode == 3 && cur_req) begin
          m_mode = 2;
          m_since = m_cyc;
        end
      end
      default: m_mode = 0;
    endcase
    for (int i = int'(SS) - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
    m_pipe[0] = int'(cur_lock);
  endtask

  task automatic step(input logic r, input logic l, input logic q);
    @(negedge clk);
    rst = r; lock_i = l; rst_req = q;
    cur_rst = r; cur_lock = l; cur_req = q;
    @(posedge clk);
    #1;
    model_edge();
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_state"}, int'(state), m_mode);
    chk({tag, "_frst"}, int'(fabric_rst), (m_mode != 3) ? 1 : 0);
    chk({tag, "_frstn"}, int'(fabric_rst_n), (m_mode == 3) ? 1 : 0);
    chk({tag, "_ready"}, int'(ready), (m_mode == 3) ? 1 : 0);
    chk({tag, "_lost"}, int'(lock_lost), m_lost);
    chk({tag, "_cnt"}, int'(loss_cnt), m_cnt);
  endtask

  // Hold lock high and count edges until READY, bounded.
  task automatic run_to_ready(output int n);
    n = 0;
    do begin
      step(1'b0, 1'b1, 1'b0);
      n++;
    end while (!ready && n < 100);
  endtask

  typedef struct {
    logic r, l, q;
    int   st;
    logic frst, rdy, lost;
    int   cnt;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic l, input int st, input logic frst);
    vec_t v;
    v.r = r; v.l = l; v.q = 1'b0; v.st = st;
    v.frst = frst; v.rdy = !frst; v.lost = 1'b0; v.cnt = 0;
    return v;
  endfunction

  vec_t tbl [17];

  initial begin
    int n, hi, lvl, len;
    for (int i = 0; i < int'(SS); i++) m_pipe[i] = 0;

    // Reset, then clean startup: edge 0 is the first edge sampling lock high.
    tbl[0]  = mk(1, 0, 0, 1);  tbl[1]  = mk(1, 0, 0, 1);
    tbl[2]  = mk(0, 1, 0, 1);  tbl[3]  = mk(0, 1, 0, 1);
    tbl[4]  = mk(0, 1, 1, 1);  tbl[5]  = mk(0, 1, 1, 1);
    tbl[6]  = mk(0, 1, 1, 1);  tbl[7]  = mk(0, 1, 1, 1);
    tbl[8]  = mk(0, 1, 2, 1);  tbl[9]  = mk(0, 1, 2, 1);
    tbl[10] = mk(0, 1, 2, 1);  tbl[11] = mk(0, 1, 2, 1);
    tbl[12] = mk(0, 1, 2, 1);  tbl[13] = mk(0, 1, 2, 1);
    tbl[14] = mk(0, 1, 2, 1);  tbl[15] = mk(0, 1, 2, 1);
    tbl[16] = mk(0, 1, 3, 0);

    for (int i = 0; i < 17; i++) begin
      step(tbl[i].r, tbl[i].l, tbl[i].q);
      chk($sformatf("tbl%0d_state", i), int'(state), tbl[i].st);
      chk($sformatf("tbl%0d_frst", i), int'(fabric_rst), int'(tbl[i].frst));
      chk($sformatf("tbl%0d_frstn", i), int'(fabric_rst_n), int'(!tbl[i].frst));
      chk($sformatf("tbl%0d_ready", i), int'(ready), int'(tbl[i].rdy));
      chk($sformatf("tbl%0d_lost", i), int'(lock_lost), int'(tbl[i].lost));
      chk($sformatf("tbl%0d_cnt", i), int'(loss_cnt), tbl[i].cnt);
    end

    // Lock loss in RUN: FABRIC_RST rises two edges after the drop is sampled.
    step(0, 0, 0); chk("loss_e0_frst", int'(fabric_rst), 0);
    step(0, 0, 0); chk("loss_e1_frst", int'(fabric_rst), 0);
    step(0, 0, 0);
    chk("loss_e2_state", int'(state), 4);
    chk("loss_e2_frst", int'(fabric_rst), 1);
    chk("loss_e2_lost", int'(lock_lost), 1);
    chk("loss_e2_cnt", int'(loss_cnt), 1);
    step(0, 0, 0); chk("loss_e3_state", int'(state), 0);
    run_to_ready(n);
    chk("relock_edges", n, UP_EDGES);

    // Soft reset from RUN holds reset for exactly RST_HOLD cycles.
    step(0, 1, 1);
    chk("sreq_state", int'(state), 2);
    chk("sreq_frst", int'(fabric_rst), 1);
    hi = 1;
    for (int i = 0; i < 50 && fabric_rst; i++) begin
      step(0, 1, 0);
      if (fabric_rst) hi++;
    end
    chk("sreq_hi_cycles", hi, int'(RH));
    chk("sreq_ready", int'(ready), 1);

    // RST_REQ during HOLD is ignored.
    step(1, 0, 0);
    n = 0;
    do begin
      step(0, 1, (n == 8));
      if (n == 8) chk("hreq_in_hold", int'(state), 2);
      n++;
    end while (!ready && n < 100);
    chk("hreq_edges", n, UP_EDGES);

    // Lock drop coincident with RST_REQ in RUN: loss wins.
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 0, 1);
    chk("prio_state", int'(state), 4);
    chk("prio_cnt", int'(loss_cnt), 1);
    step(0, 0, 0);
    chk("prio_after", int'(state), 0);

    // Repeated losses from HOLD saturate the counter.
    for (int k = 0; k < 260; k++) begin
      for (int i = 0; i < 7; i++) step(0, 1, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 0);
      chk($sformatf("sat_cnt%0d", k), int'(loss_cnt), (k + 2 < 255) ? k + 2 : 255);
    end
    chk("sat_lost", int'(lock_lost), 1);

    // RST mid-HOLD returns everything to reset values.
    for (int i = 0; i < 7; i++) step(0, 1, 0);
    chk("mid_hold_state", int'(state), 2);
    step(1, 1, 0);
    chk("rst_state", int'(state), 0);
    chk("rst_frst", int'(fabric_rst), 1);
    chk("rst_frstn", int'(fabric_rst_n), 0);
    chk("rst_ready", int'(ready), 0);
    chk("rst_lost", int'(lock_lost), 0);
    chk("rst_cnt", int'(loss_cnt), 0);

    // Randomized lock traffic with sporadic requests and resets.
    lvl = 0; len = 0;
    for (int c = 0; c < 3000; c++) begin
      if (len == 0) begin
        lvl = 1 - lvl;
        len = lvl ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 6));
      end
      len--;
      step(($urandom_range(0, 399) == 0), lvl[0], ($urandom_range(0, 15) == 0));
      chk_model($sformatf("rnd%0d", c));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pll_lock_reset_ctrl.md
# pll_lock_reset_ctrl

Lock-qualified reset generator sitting directly downstream of the fabric CCC/PLL. It runs on the PLL fabric output clock and synchronizes and filters the PLL lock flag. It holds the fabric reset asserted for a programmable interval after stable lock, then releases it. On lock loss it re-asserts reset, counts the event, and restarts the sequence. All fabric logic, including the LED blinker and the logic-analyzer capture, takes its reset from this block.

## Interface
- SYNC_STAGES, 2, synchronizer depth for PLL_LOCK_I; must be ≥2
- LOCK_FILTER, 16, consecutive synchronized-high cycles required before lock is accepted; must be ≥1
- RST_HOLD, 1024, cycles FABRIC_RST stays high after lock is accepted; must be ≥1
- CLK  in  1  PLL fabric output clock; the only clock
- RST  in  1  synchronous, active-high reset
- PLL_LOCK_I  in  1  PLL lock flag, asynchronous to CLK
- RST_REQ  in  1  single-cycle soft reset request; honoured only in RUN
- FABRIC_RST  out  1  active-high fabric reset, registered
- FABRIC_RST_N  out  1  registered complement of FABRIC_RST
- READY  out  1  high only in RUN
- LOCK_LOST  out  1  sticky; set on any lock loss; cleared only by RST
- LOSS_CNT  out  8  lock-loss event count, saturates at 255
- STATE  out  3  current state encoding, for debug and analyzer probing

## Operation
- One clock, CLK. Reset is synchronous and active-high on RST.
- On RST:
  - state = WAIT_LOCK, counter = 0, synchronizer flops = 0.
  - FABRIC_RST = 1, FABRIC_RST_N = 0, READY = 0, LOCK_LOST = 0, LOSS_CNT = 0.
- PLL_LOCK_I passes through a SYNC_STAGES flop chain. lock_s is the last stage.
- State encodings: WAIT_LOCK = 0, FILTER = 1, HOLD = 2, RUN = 3, LOST = 4.
- Transitions:
  - WAIT_LOCK: if lock_s = 1, go to FILTER and set counter = 0.
  - FILTER: if lock_s = 0, go to WAIT_LOCK. Otherwise, if counter = LOCK_FILTER−1, go to HOLD with counter = 0. Otherwise increment counter.
  - HOLD: if lock_s = 0, go to LOST. Otherwise, if counter = RST_HOLD−1, go to RUN. Otherwise increment counter.
  - RUN: if lock_s = 0, go to LOST. Else if RST_REQ = 1, go to HOLD with counter = 0.
  - LOST: unconditionally go to WAIT_LOCK on the next cycle.
- Entry into LOST from HOLD or RUN sets LOCK_LOST and increments LOSS_CNT; LOSS_CNT holds at 255.
- A lock drop during FILTER is a glitch. It returns to WAIT_LOCK without being counted.
- If lock_s falls in RUN in the same cycle RST_REQ is high, LOST takes priority and RST_REQ is discarded.
- RST_REQ is ignored in every state except RUN.
- FABRIC_RST, FABRIC_RST_N and READY are decoded from the next state and registered. They change on the same edge the state register changes.
  - FABRIC_RST = 0 only when the state is RUN.
  - READY = 1 only when the state is RUN.
- The counter is sized to $clog2(max(LOCK_FILTER, RST_HOLD)) bits and never wraps; every compare is on exact equality.
- An RST assertion mid-sequence, in any state, returns the block to its reset values on the next edge.

## Timing
- Let edge 0 be the first CLK edge at which the first synchronizer flop captures PLL_LOCK_I = 1, with lock stable thereafter.
  - lock_s = 1 after edge SYNC_STAGES−1.
  - State moves to FILTER at edge SYNC_STAGES.
  - State moves to HOLD at edge SYNC_STAGES+LOCK_FILTER.
  - FABRIC_RST falls and READY rises at edge SYNC_STAGES+LOCK_FILTER+RST_HOLD, which is 1042 with default parameters.
- Lock-loss latency: FABRIC_RST rises SYNC_STAGES edges after the first edge that samples PLL_LOCK_I = 0.
- RST_REQ sampled high in RUN at edge n: FABRIC_RST = 1 from edge n, and it falls again at edge n+RST_HOLD.
- A lock pulse shorter than LOCK_FILTER synchronized cycles never reaches HOLD.

## Structure
- Package pll_rst_pkg holds:
  - the state enum, with the 3-bit encodings above;
  - the LOSS_CNT width constant (8) and its saturation value.
- One sub-module: bit_sync, a parameterised SYNC_STAGES-deep single-bit synchronizer with synchronous reset to 0. It is instantiated once for PLL_LOCK_I.

## Test plan
- Parameters for all scenarios: SYNC_STAGES=2, LOCK_FILTER=4, RST_HOLD=8.
- Clean startup: release RST, raise PLL_LOCK_I and hold it → FABRIC_RST falls and READY rises exactly 14 edges after the first edge sampling lock high; STATE passes through 0→1→2→3; LOSS_CNT = 0.
- Glitch rejection: 3-cycle lock pulse → STATE goes 1 then back to 0; FABRIC_RST stays 1; LOCK_LOST = 0, LOSS_CNT = 0.
- Lock loss in RUN: drop PLL_LOCK_I → FABRIC_RST = 1 two edges later; STATE = 4 for one cycle then 0; LOCK_LOST = 1, LOSS_CNT = 1. Re-lock → RUN again after 14 edges.
- Soft reset: pulse RST_REQ for one cycle in RUN → FABRIC_RST high for exactly 8 cycles, then RUN. A RST_REQ pulse during HOLD has no effect.
- Priority and saturation:
  - RST_REQ coincident with lock_s falling in RUN → STATE = 4 and LOSS_CNT increments.
  - 260 loss events → LOSS_CNT = 255.
  - RST asserted mid-HOLD → all outputs return to their reset values on the next edge.
